// File: rtl/pic_bus_if.sv
// Clocked CPU bus interface for an 8259-style PIC: strobe sync, ICW init FSM, OCW decode, read mux.
// Defining PIC_POLL_CMD_EN adds the OCW3 poll command and the poll_ack output.
module pic_bus_if #(
    parameter int DATA_W   = 8,
    parameter int SYNC_STG = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cs_n,
    input  logic              rd_n,
    input  logic              wr_n,
    input  logic              a0,
    inout  wire  [DATA_W-1:0] d,
    input  logic [DATA_W-1:0] irr_in,
    input  logic [DATA_W-1:0] isr_in,
    input  logic [DATA_W-1:0] imr_in,
    output logic [DATA_W-1:0] wr_data,
    output logic [3:0]        icw_stb,
    output logic [2:0]        ocw_stb,
    output logic              init_done,
    output logic              rd_active,
    output logic              err_stb
`ifdef PIC_POLL_CMD_EN
    ,
    output logic              poll_ack
`endif
);

    localparam logic [2:0] ST_UNINIT = 3'd0;
    localparam logic [2:0] ST_W_ICW2 = 3'd1;
    localparam logic [2:0] ST_W_ICW3 = 3'd2;
    localparam logic [2:0] ST_W_ICW4 = 3'd3;
    localparam logic [2:0] ST_READY  = 3'd4;

    localparam logic RD_IRR = 1'b0;
    localparam logic RD_ISR = 1'b1;

    logic [SYNC_STG-1:0] wr_sync_q, wr_sync_d;
    logic [SYNC_STG-1:0] cs_sync_q, cs_sync_d;
    logic                wr_prev_q, wr_prev_d;
    logic                wr_s, cs_s, wr_evt;

    logic [2:0]          state_q, state_d;
    logic                sngl_q, sngl_d;
    logic                ic4_q, ic4_d;
    logic                init_done_q, init_done_d;
    logic                rd_sel_q, rd_sel_d;
    logic [DATA_W-1:0]   wr_data_q, wr_data_d;
    logic [3:0]          icw_stb_q, icw_stb_d;
    logic [2:0]          ocw_stb_q, ocw_stb_d;
    logic                err_stb_q, err_stb_d;
    logic [DATA_W-1:0]   rd_word;

`ifdef PIC_POLL_CMD_EN
    logic [SYNC_STG-1:0] rd_sync_q, rd_sync_d;
    logic                rd_prev_q, rd_prev_d;
    logic                rd_s, rd_rise;
    logic                poll_arm_q, poll_arm_d;
    logic                poll_ack_q, poll_ack_d;
    logic [DATA_W-1:0]   pend;
    logic [2:0]          lvl;
    logic [DATA_W-1:0]   poll_word;
`endif

    // Synchronisers shift toward the MSB; the MSB is the clean, synced level.
    always_comb begin
        wr_sync_d = {wr_sync_q[SYNC_STG-2:0], wr_n};
        cs_sync_d = {cs_sync_q[SYNC_STG-2:0], cs_n};
        wr_s      = wr_sync_q[SYNC_STG-1];
        cs_s      = cs_sync_q[SYNC_STG-1];
        wr_prev_d = wr_s;
        wr_evt    = wr_prev_q & ~wr_s & ~cs_s;
    end

`ifdef PIC_POLL_CMD_EN
    always_comb begin
        rd_sync_d = {rd_sync_q[SYNC_STG-2:0], rd_n};
        rd_s      = rd_sync_q[SYNC_STG-1];
        rd_prev_d = rd_s;
        rd_rise   = ~rd_prev_q & rd_s;
        pend      = irr_in & ~imr_in;
        lvl       = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (pend[i]) lvl = i[2:0];
        end
        poll_word           = '0;
        poll_word[DATA_W-1] = |pend;
        poll_word[2:0]      = lvl;
    end
`endif

    always_comb begin
        state_d     = state_q;
        sngl_d      = sngl_q;
        ic4_d       = ic4_q;
        init_done_d = init_done_q;
        rd_sel_d    = rd_sel_q;
        wr_data_d   = wr_data_q;
        icw_stb_d   = 4'b0000;
        ocw_stb_d   = 3'b000;
        err_stb_d   = 1'b0;
`ifdef PIC_POLL_CMD_EN
        poll_arm_d  = poll_arm_q;
        poll_ack_d  = 1'b0;
        if (rd_rise && poll_arm_q) begin
            poll_arm_d = 1'b0;
            poll_ack_d = 1'b1;
        end
`endif
        if (wr_evt) begin
            // ICW1 restarts initialisation from any state.
            if (!a0 && d[4]) begin
                sngl_d      = d[1];
                ic4_d       = d[0];
                icw_stb_d   = 4'b0001;
                init_done_d = 1'b0;
                rd_sel_d    = RD_IRR;
                wr_data_d   = d;
                state_d     = ST_W_ICW2;
`ifdef PIC_POLL_CMD_EN
                poll_arm_d  = 1'b0;
`endif
            end else begin
                case (state_q)
                    ST_UNINIT: err_stb_d = 1'b1;
                    ST_W_ICW2: begin
                        if (a0) begin
                            icw_stb_d = 4'b0010;
                            wr_data_d = d;
                            if (!sngl_q) begin
                                state_d = ST_W_ICW3;
                            end else if (ic4_q) begin
                                state_d = ST_W_ICW4;
                            end else begin
                                state_d     = ST_READY;
                                init_done_d = 1'b1;
                            end
                        end else begin
                            err_stb_d = 1'b1;
                        end
                    end
                    ST_W_ICW3: begin
                        if (a0) begin
                            icw_stb_d = 4'b0100;
                            wr_data_d = d;
                            if (ic4_q) begin
                                state_d = ST_W_ICW4;
                            end else begin
                                state_d     = ST_READY;
                                init_done_d = 1'b1;
                            end
                        end else begin
                            err_stb_d = 1'b1;
                        end
                    end
                    ST_W_ICW4: begin
                        if (a0) begin
                            icw_stb_d   = 4'b1000;
                            wr_data_d   = d;
                            state_d     = ST_READY;
                            init_done_d = 1'b1;
                        end else begin
                            err_stb_d = 1'b1;
                        end
                    end
                    ST_READY: begin
                        // d[4] is known to be 0 here, so d[3] alone separates OCW2 from OCW3.
                        if (a0) begin
                            ocw_stb_d = 3'b001;
                            wr_data_d = d;
                        end else if (d[4:3] == 2'b00) begin
                            ocw_stb_d = 3'b010;
                            wr_data_d = d;
                        end else if (!d[7]) begin
                            ocw_stb_d = 3'b100;
                            wr_data_d = d;
                            if (d[1]) rd_sel_d = d[0] ? RD_ISR : RD_IRR;
`ifdef PIC_POLL_CMD_EN
                            if (d[2]) poll_arm_d = 1'b1;
`endif
                        end else begin
                            err_stb_d = 1'b1;
                        end
                    end
                    default: state_d = ST_UNINIT;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_sync_q   <= '1;
            cs_sync_q   <= '1;
            wr_prev_q   <= 1'b1;
            state_q     <= ST_UNINIT;
            sngl_q      <= 1'b0;
            ic4_q       <= 1'b0;
            init_done_q <= 1'b0;
            rd_sel_q    <= RD_IRR;
            wr_data_q   <= '0;
            icw_stb_q   <= 4'b0000;
            ocw_stb_q   <= 3'b000;
            err_stb_q   <= 1'b0;
        end else begin
            wr_sync_q   <= wr_sync_d;
            cs_sync_q   <= cs_sync_d;
            wr_prev_q   <= wr_prev_d;
            state_q     <= state_d;
            sngl_q      <= sngl_d;
            ic4_q       <= ic4_d;
            init_done_q <= init_done_d;
            rd_sel_q    <= rd_sel_d;
            wr_data_q   <= wr_data_d;
            icw_stb_q   <= icw_stb_d;
            ocw_stb_q   <= ocw_stb_d;
            err_stb_q   <= err_stb_d;
        end
    end

`ifdef PIC_POLL_CMD_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_sync_q  <= '1;
            rd_prev_q  <= 1'b1;
            poll_arm_q <= 1'b0;
            poll_ack_q <= 1'b0;
        end else begin
            rd_sync_q  <= rd_sync_d;
            rd_prev_q  <= rd_prev_d;
            poll_arm_q <= poll_arm_d;
            poll_ack_q <= poll_ack_d;
        end
    end

    assign poll_ack = poll_ack_q;
`endif

    // Read path is purely combinational from the raw strobes.
    always_comb begin
        if (a0) begin
            rd_word = imr_in;
        end else if (rd_sel_q == RD_ISR) begin
            rd_word = isr_in;
        end else begin
            rd_word = irr_in;
        end
`ifdef PIC_POLL_CMD_EN
        if (!a0 && poll_arm_q) rd_word = poll_word;
`endif
    end

    assign rd_active = ~rd_n & ~cs_n;
    assign d         = rd_active ? rd_word : {DATA_W{1'bz}};

    assign wr_data   = wr_data_q;
    assign icw_stb   = icw_stb_q;
    assign ocw_stb   = ocw_stb_q;
    assign init_done = init_done_q;
    assign err_stb   = err_stb_q;

endmodule

// File: tb/tb_pic_bus_if.sv
// Bench for pic_bus_if: directed vector table, hand sequences and a randomized run
// against a queue-based reference model of the ICW/OCW protocol.
module tb_pic_bus_if;
    localparam int DATA_W   = 8;
    localparam int SYNC_STG = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cs_n = 1'b1, rd_n = 1'b1, wr_n = 1'b1, a0 = 1'b0;
    logic [7:0] irr_in = 8'h00, isr_in = 8'h00, imr_in = 8'h00;
    logic [7:0] tb_d = 8'h00;
    logic       tb_d_en = 1'b0;
    wire  [7:0] d_bus;
    logic [7:0] wr_data;
    logic [3:0] icw_stb;
    logic [2:0] ocw_stb;
    logic       init_done, rd_active, err_stb;
`ifdef PIC_POLL_CMD_EN
    logic       poll_ack;
`endif

    assign d_bus = tb_d_en ? tb_d : 8'bz;

    always #5 clk = ~clk;

    pic_bus_if #(.DATA_W(DATA_W), .SYNC_STG(SYNC_STG)) dut (
        .clk(clk), .rst(rst), .cs_n(cs_n), .rd_n(rd_n), .wr_n(wr_n), .a0(a0),
        .d(d_bus), .irr_in(irr_in), .isr_in(isr_in), .imr_in(imr_in),
        .wr_data(wr_data), .icw_stb(icw_stb), .ocw_stb(ocw_stb),
        .init_done(init_done), .rd_active(rd_active), .err_stb(err_stb)
`ifdef PIC_POLL_CMD_EN
        , .poll_ack(poll_ack)
`endif
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: remaining ICW numbers are kept in a queue built at ICW1.
    bit         m_inited;
    int         m_todo[$];
    bit         m_done;
    bit         m_isr;
    logic [7:0] m_wr;
    bit         m_poll;

    task automatic model_reset();
        m_inited = 0; m_todo.delete(); m_done = 0; m_isr = 0; m_wr = 8'h00; m_poll = 0;
    endtask

    task automatic model_write(input bit wa0, input logic [7:0] v,
                               output logic [3:0] e_icw, output logic [2:0] e_ocw, output logic e_err);
        int n;
        e_icw = 4'b0; e_ocw = 3'b0; e_err = 1'b0;
        if (!wa0 && v[4]) begin
            m_inited = 1; m_todo.delete(); m_todo.push_back(2);
            if (!v[1]) m_todo.push_back(3);
            if (v[0]) m_todo.push_back(4);
            m_done = 0; m_isr = 0; m_wr = v; m_poll = 0; e_icw = 4'b0001;
        end else if (!m_inited) begin
            e_err = 1'b1;
        end else if (m_todo.size() > 0) begin
            if (wa0) begin
                n = m_todo.pop_front();
                e_icw = 4'(1 << (n - 1));
                m_wr = v;
                if (m_todo.size() == 0) m_done = 1;
            end else begin
                e_err = 1'b1;
            end
        end else if (wa0) begin
            e_ocw = 3'b001; m_wr = v;
        end else if (v[4:3] == 2'b00) begin
            e_ocw = 3'b010; m_wr = v;
        end else if (!v[7]) begin
            e_ocw = 3'b100; m_wr = v;
            if (v[1]) m_isr = v[0];
`ifdef PIC_POLL_CMD_EN
            if (v[2]) m_poll = 1;
`endif
        end else begin
            e_err = 1'b1;
        end
    endtask

    function automatic logic [7:0] model_rd(input bit ra0);
        logic [7:0] p;
        int         lv;
        if (ra0) return imr_in;
        if (m_poll) begin
            p  = irr_in & ~imr_in;
            lv = 0;
            for (int i = 0; i < 8; i++) begin
                if (p[i]) begin
                    lv = i;
                    break;
                end
            end
            return (p != 0 ? 8'h80 : 8'h00) | 8'(lv);
        end
        return m_isr ? isr_in : irr_in;
    endfunction

    task automatic do_write(input bit wa0, input logic [7:0] v, output logic [3:0] s_icw,
                            output logic [2:0] s_ocw, output logic s_err, output int stray);
        stray = 0; s_icw = 4'b0; s_ocw = 3'b0; s_err = 1'b0;
        @(negedge clk);
        a0 = wa0; tb_d = v; tb_d_en = 1'b1; cs_n = 1'b0; wr_n = 1'b0;
        for (int c = 1; c <= SYNC_STG + 5; c++) begin
            @(negedge clk);
            if (c == SYNC_STG + 1) begin
                s_icw = icw_stb; s_ocw = ocw_stb; s_err = err_stb;
            end else if (icw_stb != 0 || ocw_stb != 0 || err_stb) begin
                stray++;
            end
        end
        wr_n = 1'b1; cs_n = 1'b1; tb_d_en = 1'b0;
        for (int c = 0; c < SYNC_STG + 3; c++) begin
            @(negedge clk);
            if (icw_stb != 0 || ocw_stb != 0 || err_stb) stray++;
        end
    endtask

    task automatic write_model_chk(input string name, input bit wa0, input logic [7:0] v);
        logic [3:0] s_icw, e_icw;
        logic [2:0] s_ocw, e_ocw;
        logic       s_err, e_err;
        int         stray;
        do_write(wa0, v, s_icw, s_ocw, s_err, stray);
        model_write(wa0, v, e_icw, e_ocw, e_err);
        chk({name, "_icw"}, 32'(s_icw), 32'(e_icw));
        chk({name, "_ocw"}, 32'(s_ocw), 32'(e_ocw));
        chk({name, "_err"}, 32'(s_err), 32'(e_err));
        chk({name, "_stray"}, 32'(stray), 32'd0);
        chk({name, "_done"}, 32'(init_done), 32'(m_done));
        chk({name, "_wrdata"}, 32'(wr_data), 32'(m_wr));
    endtask

    task automatic read_chk(input string name, input bit ra0, input logic [7:0] exp);
        logic [7:0] val;
        logic       act;
        int         acks;
        acks = 0;
        @(negedge clk);
        a0 = ra0; cs_n = 1'b0; rd_n = 1'b0;
        #1;
        val = d_bus; act = rd_active;
        @(negedge clk);
        rd_n = 1'b1; cs_n = 1'b1;
        for (int c = 0; c < SYNC_STG + 3; c++) begin
            @(negedge clk);
`ifdef PIC_POLL_CMD_EN
            if (poll_ack) acks++;
`endif
        end
        chk({name, "_data"}, 32'(val), 32'(exp));
        chk({name, "_active"}, 32'(act), 32'd1);
`ifdef PIC_POLL_CMD_EN
        chk({name, "_pollack"}, 32'(acks), m_poll ? 32'd1 : 32'd0);
`endif
        m_poll = 0;
    endtask

    task automatic do_reset(input string name);
        @(negedge clk);
        rst = 1'b1; cs_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1; tb_d_en = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        chk({name, "_icw"}, 32'(icw_stb), 32'd0);
        chk({name, "_ocw"}, 32'(ocw_stb), 32'd0);
        chk({name, "_err"}, 32'(err_stb), 32'd0);
        chk({name, "_done"}, 32'(init_done), 32'd0);
        chk({name, "_wrdata"}, 32'(wr_data), 32'd0);
    endtask

    typedef struct {
        bit         a0;
        logic [7:0] v;
        logic [3:0] icw;
        logic [2:0] ocw;
        logic       err;
        logic       done;
        logic [7:0] wr;
    } vec_t;

    vec_t tbl[14];

    initial begin
        logic [3:0] s_icw, e_icw;
        logic [2:0] s_ocw, e_ocw;
        logic       s_err, e_err;
        int         stray;
        int         r;
        logic [7:0] ev;

        tbl[0]  = '{1'b0, 8'h13, 4'b0001, 3'b000, 1'b0, 1'b0, 8'h13};
        tbl[1]  = '{1'b1, 8'h20, 4'b0010, 3'b000, 1'b0, 1'b0, 8'h20};
        tbl[2]  = '{1'b1, 8'h01, 4'b1000, 3'b000, 1'b0, 1'b1, 8'h01};
        tbl[3]  = '{1'b0, 8'h11, 4'b0001, 3'b000, 1'b0, 1'b0, 8'h11};
        tbl[4]  = '{1'b1, 8'h20, 4'b0010, 3'b000, 1'b0, 1'b0, 8'h20};
        tbl[5]  = '{1'b0, 8'h00, 4'b0000, 3'b000, 1'b1, 1'b0, 8'h20};
        tbl[6]  = '{1'b1, 8'h04, 4'b0100, 3'b000, 1'b0, 1'b0, 8'h04};
        tbl[7]  = '{1'b1, 8'h01, 4'b1000, 3'b000, 1'b0, 1'b1, 8'h01};
        tbl[8]  = '{1'b1, 8'hFF, 4'b0000, 3'b001, 1'b0, 1'b1, 8'hFF};
        tbl[9]  = '{1'b0, 8'h20, 4'b0000, 3'b010, 1'b0, 1'b1, 8'h20};
        tbl[10] = '{1'b0, 8'h0B, 4'b0000, 3'b100, 1'b0, 1'b1, 8'h0B};
        tbl[11] = '{1'b0, 8'h88, 4'b0000, 3'b000, 1'b1, 1'b1, 8'h0B};
        tbl[12] = '{1'b0, 8'h12, 4'b0001, 3'b000, 1'b0, 1'b0, 8'h12};
        tbl[13] = '{1'b1, 8'h40, 4'b0010, 3'b000, 1'b0, 1'b1, 8'h40};

        repeat (3) @(negedge clk);
        do_reset("reset0");

        for (int i = 0; i < 14; i++) begin
            do_write(tbl[i].a0, tbl[i].v, s_icw, s_ocw, s_err, stray);
            model_write(tbl[i].a0, tbl[i].v, e_icw, e_ocw, e_err);
            chk($sformatf("vec%0d_icw", i), 32'(s_icw), 32'(tbl[i].icw));
            chk($sformatf("vec%0d_ocw", i), 32'(s_ocw), 32'(tbl[i].ocw));
            chk($sformatf("vec%0d_err", i), 32'(s_err), 32'(tbl[i].err));
            chk($sformatf("vec%0d_stray", i), 32'(stray), 32'd0);
            chk($sformatf("vec%0d_done", i), 32'(init_done), 32'(tbl[i].done));
            chk($sformatf("vec%0d_wrdata", i), 32'(wr_data), 32'(tbl[i].wr));
        end

        // Read path and OCW3 register selection.
        irr_in = 8'h05; isr_in = 8'h80; imr_in = 8'h3C;
        read_chk("rd_irr", 1'b0, 8'h05);
        write_model_chk("ocw3_isr", 1'b0, 8'h0B);
        read_chk("rd_isr", 1'b0, 8'h80);
        read_chk("rd_imr", 1'b1, 8'h3C);
        write_model_chk("ocw3_norr", 1'b0, 8'h08);
        read_chk("rd_isr_held", 1'b0, 8'h80);
        write_model_chk("ocw3_irr", 1'b0, 8'h0A);
        read_chk("rd_irr_back", 1'b0, 8'h05);

        // Deselected read: DUT must not drive, so the bench's own drive is seen.
        @(negedge clk);
        a0 = 1'b0; cs_n = 1'b1; rd_n = 1'b0; tb_d = 8'h5A; tb_d_en = 1'b1;
        #1;
        chk("desel_active", 32'(rd_active), 32'd0);
        chk("desel_bus", 32'(d_bus), 32'h5A);
        @(negedge clk);
        rd_n = 1'b1; tb_d_en = 1'b0;
        repeat (SYNC_STG + 3) @(negedge clk);

`ifdef PIC_POLL_CMD_EN
        irr_in = 8'h30; imr_in = 8'h10;
        write_model_chk("ocw3_poll", 1'b0, 8'h0C);
        read_chk("rd_poll", 1'b0, 8'h85);
        read_chk("rd_after_poll", 1'b0, 8'h30);
`endif

        // ICW1 while ready drops init_done; reset mid-W_ICW2 returns to uninitialised.
        write_model_chk("icw1_ready", 1'b0, 8'h13);
        chk("icw1_ready_done_low", 32'(init_done), 32'd0);
        do_reset("reset_mid");
        write_model_chk("uninit_a0w", 1'b1, 8'h20);
        write_model_chk("uninit_ocw2", 1'b0, 8'h20);

        for (int n = 0; n < 160; n++) begin
            r = $urandom_range(0, 29);
            irr_in = 8'($urandom); isr_in = 8'($urandom); imr_in = 8'($urandom);
            if (r == 0) begin
                do_reset("rnd_reset");
            end else if (r < 9) begin
                ev = model_rd(r[0]);
                read_chk("rnd_read", r[0], ev);
            end else begin
                write_model_chk("rnd_write", 1'($urandom_range(0, 1)), 8'($urandom));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pic_bus_if.md
Name: pic_bus_if

Overview:
- Clocked, parametrised CPU bus interface for the 8259-style PIC.
- Synchronises the asynchronous rd_n/wr_n strobes and runs the ICW1..ICW4 initialisation sequence as an explicit FSM.
- Decodes OCW1..OCW3 and emits single-cycle command strobes with the latched data word to the control logic.
- Drives the tri-state data bus with IRR, ISR or IMR, selected by the OCW3 read-register state.

Parameters:
- DATA_W, 8, data bus width; must be >= 8. Bits [7:0] are used for command decode; the full word is forwarded.
- SYNC_STG, 2, synchroniser depth for rd_n/wr_n/cs_n; allowed range 2..4.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- cs_n  in  1  chip select, active low
- rd_n  in  1  CPU read strobe, active low
- wr_n  in  1  CPU write strobe, active low
- a0  in  1  register address bit
- d  inout  DATA_W  CPU data bus
- irr_in  in  DATA_W  interrupt request register
- isr_in  in  DATA_W  in-service register
- imr_in  in  DATA_W  interrupt mask register
- wr_data  out  DATA_W  last accepted command word
- icw_stb  out  4  one-hot pulse; bit i-1 = ICWi accepted
- ocw_stb  out  3  one-hot pulse; bit i-1 = OCWi accepted
- init_done  out  1  high once the ICW sequence is complete
- rd_active  out  1  high while ~rd_n & ~cs_n (combinational)
- err_stb  out  1  pulse on an illegal or out-of-sequence write

Behaviour:
- Reset:
  - FSM = UNINIT; wr_data = 0; icw_stb, ocw_stb, err_stb = 0; init_done = 0.
  - rd_sel = IRR.
  - Synchroniser flops preset to 1 (inactive), so no false edge is seen after reset release.
- Write detection:
  - wr_n and cs_n each pass through SYNC_STG flops.
  - A write event is the cycle in which synced wr_n goes 1->0 while synced cs_n = 0.
  - a0 and d are sampled at that edge; the CPU holds them stable for >= SYNC_STG+2 clocks.
  - Strobes and wr_data update on the following edge, i.e. SYNC_STG+1 cycles after wr_n falls.
  - Strobes are high for exactly one cycle. One write produces exactly one event, however long wr_n stays low.
- ICW1 (a0=0, d[4]=1):
  - Accepted in any state, including mid-init and READY.
  - Latches sngl=d[1] and ic4=d[0]; pulses icw_stb[0].
  - Clears init_done, sets rd_sel=IRR, moves to W_ICW2.
- FSM states: UNINIT, W_ICW2, W_ICW3, W_ICW4, READY.
- UNINIT: any non-ICW1 write -> err_stb, no state change.
- W_ICW2:
  - a0=1 -> icw_stb[1].
  - Next state: W_ICW3 if sngl=0, else W_ICW4 if ic4=1, else READY.
- W_ICW3: a0=1 -> icw_stb[2]; next state W_ICW4 if ic4=1, else READY.
- W_ICW4: a0=1 -> icw_stb[3]; next state READY.
- In any W_* state, an a0=0 write with d[4]=0 -> err_stb, state held.
- Entry to READY sets init_done=1 in the same cycle as the final icw_stb.
- READY decode:
  - a0=1 -> OCW1.
  - a0=0, d[4:3]=00 -> OCW2.
  - a0=0, d[4:3]=01, d[7]=0 -> OCW3.
  - a0=0, d[4:3]=01, d[7]=1 -> err_stb, no ocw_stb.
- OCW3 with d[1]=1 (RR): rd_sel = d[0] ? ISR : IRR. With d[1]=0, rd_sel is unchanged.
- wr_data is updated only on accepted ICW/OCW writes; it holds on errors.
- Read path (asynchronous, no clock latency):
  - d is driven when ~rd_n & ~cs_n, otherwise high-Z.
  - Value driven: a0=1 -> imr_in; a0=0 -> irr_in or isr_in per rd_sel.
- A write and a read asserted together is a CPU protocol violation. The read drive still follows the rule above and the write is still processed.
- rst asserted mid-sequence returns to UNINIT; a new ICW1 is required.

Optional Feature:
- Macro: PIC_POLL_CMD_EN.
- When defined:
  - OCW3 with d[2]=1 (P) arms poll mode; rd_sel is unaffected.
  - The next a0=0 read drives the poll word {irq_pend, zeros, lvl[2:0]}.
  - irq_pend = |(irr_in & ~imr_in); lvl = index of the lowest set bit of irr_in & ~imr_in.
  - Synced rd rising edge then disarms poll mode and pulses output poll_ack (1 bit) for one cycle.
- When undefined:
  - d[2] is ignored; the poll_ack port does not exist.

Test Plan:
- Reset, then ICW1=0x13, ICW2=0x20, ICW4=0x01: icw_stb pulses 0001, 0010, 1000; ICW3 skipped; init_done=1 with the ICW4 pulse; wr_data=0x01.
- ICW1=0x11 (sngl=0, ic4=1), then ICW2, ICW3=0x04, ICW4: all four strobes in order; a0=0/0x00 write in W_ICW3 -> err_stb, state held.
- After init: a0=1/0xFF -> ocw_stb=001; a0=0/0x20 -> 010; a0=0/0x0B -> 100; a0=0/0x88 -> err_stb only.
- irr_in=0x05, isr_in=0x80, imr_in=0x3C: read a0=0 -> 0x05; OCW3 0x0B, read -> 0x80; read a0=1 -> 0x3C; cs_n=1 -> d high-Z.
- ICW1 in READY, then rst mid-W_ICW2: init_done drops on ICW1; after rst, FSM=UNINIT and an a0=1 write -> err_stb.
- PIC_POLL_CMD_EN: irr_in=0x30, imr_in=0x10, OCW3 0x0C, read -> 0x85; poll_ack pulses; next read -> irr_in.
